// File: rtl/scan_doubler_pkg.sv
// scan_doubler_pkg: shared write-FSM states, VGA 640x480 timing constants, pixel type
package scan_doubler_pkg;
  typedef enum logic [1:0] {W_SYNC, W_FILL, W_FULL} wstate_e;
  localparam int H_VIS  = 640;
  localparam int H_LAST = 799;
  localparam int V_VIS  = 480;
  localparam int V_LAST = 524;
  localparam int PIX_W  = 12;
  typedef logic [PIX_W-1:0] pixel_t;
  function automatic logic swap_pos(input logic [9:0] x, input logic [9:0] y);
    return x == 10'(H_LAST) && ((y < 10'(V_VIS) && y[0]) || y == 10'(V_LAST));
  endfunction
endpackage

// File: rtl/scan_doubler_line_buf.sv
// line_buf: single-write-port line RAM with combinational read
module line_buf #(
  parameter int N  = 320,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [8:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [8:0]    ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/scan_doubler.sv
// scan_doubler: ping-pong line buffers doubling a SRC_W x SRC_H stream onto a 640x480 VGA raster.
// Define SCAN_DOUBLER_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_valid,
  input  logic          pix_sof,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  input  logic          pixel_tick,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          video_on,
  output logic [DW-1:0] rgb,
  output logic          underflow
`ifdef SCAN_DOUBLER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]   underflow_cnt
`endif
);
  wstate_e       wstate_q, wstate_d;
  logic [8:0]    wptr_q, wptr_d;
  logic [7:0]    src_line_q, src_line_d;
  logic          sel_q, sel_d;
  logic [DW-1:0] rgb_q, rgb_d;
  logic          underflow_q, underflow_d;
  logic          xfer, last_wr, full, swap_ev, we;
  logic [8:0]    wa, ra;
  logic [DW-1:0] rd0, rd1, show_px;

  assign pix_ready = wstate_q != W_FULL;
  assign xfer      = pix_valid && pix_ready && reset_n;
  assign last_wr   = wstate_q == W_FILL && xfer && !pix_sof && wptr_q == 9'(SRC_W-1);
  // a line finishing on the swap edge counts as full: the write lands before roles flip
  assign full      = wstate_q == W_FULL || last_wr;
  assign swap_ev   = pixel_tick && swap_pos(pixel_x, pixel_y);
  assign we        = xfer && (wstate_q == W_FILL || pix_sof);
  assign wa        = pix_sof ? 9'd0 : wptr_q;
  assign ra        = pixel_x < 10'(H_VIS) ? pixel_x[9:1] : 9'd0;
  assign show_px   = sel_q ? rd0 : rd1;

  line_buf #(.N(SRC_W), .DW(DW)) u_buf0 (
    .clk(clk), .we(we && !sel_q), .wa(wa), .wd(pix_data), .ra(ra), .rd(rd0)
  );
  line_buf #(.N(SRC_W), .DW(DW)) u_buf1 (
    .clk(clk), .we(we && sel_q), .wa(wa), .wd(pix_data), .ra(ra), .rd(rd1)
  );

  always_comb begin
    wstate_d    = wstate_q;
    wptr_d      = wptr_q;
    src_line_d  = src_line_q;
    sel_d       = sel_q;
    underflow_d = swap_ev && !full;
    rgb_d       = pixel_tick ? ((video_on && pixel_x < 10'(H_VIS)) ? show_px : '0) : rgb_q;
    if (xfer && pix_sof) begin
      wstate_d   = W_FILL;
      wptr_d     = 9'd1;
      src_line_d = '0;
    end else if (xfer && wstate_q == W_FILL) begin
      wptr_d   = last_wr ? 9'd0 : wptr_q + 9'd1;
      wstate_d = last_wr ? W_FULL : W_FILL;
    end
    if (swap_ev && full) begin
      sel_d      = ~sel_q;
      wptr_d     = '0;
      src_line_d = src_line_q == 8'(SRC_H-1) ? 8'd0 : src_line_q + 8'd1;
      wstate_d   = src_line_q == 8'(SRC_H-1) ? W_SYNC : W_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wstate_q    <= W_SYNC;
      wptr_q      <= '0;
      src_line_q  <= '0;
      sel_q       <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wptr_q      <= wptr_d;
      src_line_q  <= src_line_d;
      sel_q       <= sel_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign rgb       = rgb_q;
  assign underflow = underflow_q;

`ifdef SCAN_DOUBLER_UNDERFLOW_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else if (underflow_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign underflow_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: directed checks of fill, swap, starvation, backpressure and blanking
module tb_scan_doubler;
  import scan_doubler_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, pixel_tick = 1'b0, video_on = 1'b0;
  logic [11:0] pix_data = '0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        pix_ready, underflow;
  logic [11:0] rgb;
  int          n_chk = 0, n_fail = 0;
`ifdef SCAN_DOUBLER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  scan_doubler dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .rgb(rgb),
    .underflow(underflow)
`ifdef SCAN_DOUBLER_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d, input logic s);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    clk1();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic tick(input int x, input int y, input logic v);
    pixel_tick = 1'b1;
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    video_on   = v;
    clk1();
    pixel_tick = 1'b0;
  endtask

  function automatic logic [11:0] px(input int l, input int i);
    return 12'((i + 1) ^ (l << 9));
  endfunction

  task automatic feed(input int l, input logic first_sof);
    for (int i = 0; i < 320; i++) push(px(l, i), first_sof && i == 0);
  endtask

  initial begin
    repeat (3) clk1();
    check("reset_rgb", 16'(rgb), 16'h000);
    check("reset_ready", 16'(pix_ready), 16'h1);
    check("reset_underflow", 16'(underflow), 16'h0);
    check("reset_wstate", 16'(dut.wstate_q), 16'(W_SYNC));
    reset_n = 1'b1;
    push(12'h555, 1'b0);
    push(12'h556, 1'b0);
    check("sync_discard_state", 16'(dut.wstate_q), 16'(W_SYNC));
    check("sync_ready", 16'(pix_ready), 16'h1);
    push(12'hFFF, 1'b1);
    for (int i = 1; i < 100; i++) push(12'hEEE, 1'b0);
    check("midline_wptr", 16'(dut.wptr_q), 16'd100);
    feed(0, 1'b1);
    check("line0_full", 16'(dut.wstate_q), 16'(W_FULL));
    check("full_not_ready", 16'(pix_ready), 16'h0);
    pix_valid = 1'b1;
    pix_data  = px(1, 0);
    clk1();
    check("backpressure_ready", 16'(pix_ready), 16'h0);
    tick(799, 524, 1'b0);
    check("swap_ready", 16'(pix_ready), 16'h1);
    check("swap524_no_underflow", 16'(underflow), 16'h0);
    clk1();
    pix_valid = 1'b0;
    for (int i = 1; i < 320; i++) push(px(1, i), 1'b0);
    tick(0, 0, 1'b1);   check("row0_col0", 16'(rgb), 16'h001);
    tick(1, 0, 1'b1);   check("row0_col1", 16'(rgb), 16'h001);
    tick(638, 0, 1'b1); check("row0_col638", 16'(rgb), 16'h140);
    tick(639, 0, 1'b1); check("row0_col639", 16'(rgb), 16'h140);
    clk1();             check("rgb_hold", 16'(rgb), 16'h140);
    tick(640, 0, 1'b1); check("col640_black", 16'(rgb), 16'h000);
    tick(1, 1, 1'b1);   check("row1_col1", 16'(rgb), 16'h001);
    tick(10, 1, 1'b0);  check("blank_black", 16'(rgb), 16'h000);
    tick(799, 1, 1'b0); check("swap1_no_underflow", 16'(underflow), 16'h0);
    tick(0, 2, 1'b1);   check("row2_col0", 16'(rgb), 16'h201);
    tick(639, 3, 1'b1); check("row3_col639", 16'(rgb), 16'h340);
    for (int l = 2; l <= 5; l++) begin
      feed(l, 1'b0);
      tick(799, 2 * l - 1, 1'b0);
    end
    tick(4, 10, 1'b1);  check("row10_line5", 16'(rgb), 16'hA03);
    tick(799, 10, 1'b0); check("even_row_no_swap", 16'(underflow), 16'h0);
    tick(799, 11, 1'b0); check("starve_row11", 16'(underflow), 16'h1);
    clk1();             check("underflow_pulse_end", 16'(underflow), 16'h0);
    tick(4, 12, 1'b1);  check("row12_repeat", 16'(rgb), 16'hA03);
    tick(799, 13, 1'b0); check("starve_row13", 16'(underflow), 16'h1);
    tick(4, 14, 1'b1);  check("row14_repeat", 16'(rgb), 16'hA03);
    for (int i = 0; i < 319; i++) push(px(6, i), 1'b0);
    pix_valid = 1'b1;
    pix_data  = px(6, 319);
    tick(799, 15, 1'b0);
    pix_valid = 1'b0;
    check("coincide_no_underflow", 16'(underflow), 16'h0);
    check("coincide_state", 16'(dut.wstate_q), 16'(W_FILL));
    tick(0, 16, 1'b1);   check("row16_col0", 16'(rgb), 16'hC01);
    tick(639, 16, 1'b1); check("row16_col639", 16'(rgb), 16'hD40);
    for (int i = 0; i < 5; i++) push(px(7, i), 1'b0);
    reset_n   = 1'b0;
    pix_valid = 1'b1;
    clk1();
    check("midreset_state", 16'(dut.wstate_q), 16'(W_SYNC));
    check("midreset_wptr", 16'(dut.wptr_q), 16'd0);
    check("midreset_ready", 16'(pix_ready), 16'h1);
    check("midreset_rgb", 16'(rgb), 16'h000);
    pix_valid = 1'b0;
    reset_n   = 1'b1;
`ifdef SCAN_DOUBLER_UNDERFLOW_CNT_EN
    check("cnt_reset", underflow_cnt, 16'h0000);
    pixel_tick = 1'b1;
    pixel_x    = 10'd799;
    pixel_y    = 10'd1;
    video_on   = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    pixel_tick = 1'b0;
    clk1();
    clk1();
    check("cnt_saturate", underflow_cnt, 16'hFFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_doubler.md
SCAN_DOUBLER -- requirements
Module: scan_doubler

Interface
REQ-001 Parameters: SRC_W, default 320, source pixels per line; SRC_H, default 240, source lines per frame; DW, default 12, pixel width in 4:4:4 RGB.
REQ-002 clk  in  1  system clock (100 MHz).
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 pix_valid  in  1  upstream pixel valid.
REQ-005 pix_sof  in  1  qualifies the first pixel of a frame; sampled only with pix_valid.
REQ-006 pix_data  in  DW  upstream pixel, row-major order.
REQ-007 pix_ready  out  1  block accepts pix_data this cycle.
REQ-008 pixel_tick  in  1  one-clk strobe per VGA pixel.
REQ-009 pixel_x  in  10  VGA column, 0..799.
REQ-010 pixel_y  in  10  VGA row, 0..524.
REQ-011 video_on  in  1  visible-area flag.
REQ-012 rgb  out  DW  registered VGA colour.
REQ-013 underflow  out  1  one-clk pulse when a required swap finds the fill buffer not full.

Function
REQ-014 Storage: two SRC_W x DW line buffers with combinational read; the SHALL designations are fill buffer (write side) and show buffer (read side).
REQ-015 Handshake: a transfer occurs on a clk edge with pix_valid and pix_ready both high.
REQ-016 pix_ready = (wstate == W_FILL).
REQ-017 Write FSM W_SYNC: on entry, wptr=0; on a transfer with pix_sof=1, store to fill[0], set wptr=1, set src_line=0, go to W_FILL.
REQ-018 W_SYNC: transfers without pix_sof are accepted and discarded (pix_ready=1 in W_SYNC as an exception to REQ-016).
REQ-019 W_FILL: each transfer writes fill[wptr] and increments wptr; on the transfer with wptr==SRC_W-1, go to W_FULL.
REQ-020 W_FILL, pix_sof=1 mid-line: restart at wptr=1 with that pixel stored at index 0, set src_line=0.
REQ-021 W_FULL: hold until a swap, then set wptr=0 and src_line+1; go to W_FILL, or to W_SYNC when src_line was SRC_H-1.
REQ-022 Swap event occurs on a pixel_tick when pixel_x==799 and either (pixel_y<480 and pixel_y odd) or pixel_y==524.
REQ-023 At a swap event with wstate==W_FULL, exchange buffer roles in the same cycle.
REQ-024 At a swap event with wstate!=W_FULL, keep roles unchanged (the previous line repeats) and pulse underflow.
REQ-025 Swap and the last write coinciding: the write completes first, so the swap succeeds.
REQ-026 On each pixel_tick, rgb <= video_on ? show[pixel_x[9:1]] : 0; pixel_x>=640 outputs 0 regardless.
REQ-027 Effective scaling: each source pixel spans 2 columns and 2 rows, for 320x240 -> 640x480.
REQ-028 Latency: rgb is valid one clk after the pixel_tick that addresses it; rgb holds between ticks.
REQ-029 Arithmetic: wptr and the read index are 9 bits and src_line is 8 bits; no value exceeds SRC_W-1 or SRC_H-1.

Reset
REQ-030 On reset_n=0 at a clk edge: wstate=W_SYNC, wptr=0, src_line=0, buffer-select=0, rgb=0, underflow=0, pix_ready=1.
REQ-031 Buffer contents are not reset; the first displayed line after reset may be arbitrary until the first swap.
REQ-032 Reset mid-line discards the partial line; no transfer is accepted in the reset cycle.

Configuration
REQ-033 With macro SCAN_DOUBLER_UNDERFLOW_CNT_EN defined: add output underflow_cnt (16 bits), which saturates at 16'hFFFF, increments on each underflow pulse, and clears on reset.
REQ-034 Without SCAN_DOUBLER_UNDERFLOW_CNT_EN: the port is absent, and the underflow pulse behaviour is unchanged.

Structure
REQ-035 Shared package scan_doubler_pkg holds: the wstate enum (W_SYNC, W_FILL, W_FULL), the VGA constants H_VIS=640, H_LAST=799, V_VIS=480, V_LAST=524, and the pixel typedef (DW bits).
REQ-036 One sub-module, line_buf (single-write, async-read SRC_W x DW RAM), instantiated twice.

Verification
REQ-037 Reset: hold reset_n=0 for 3 clks -> rgb=0, pix_ready=1, underflow=0, wstate=W_SYNC.
REQ-038 Frame fill: feed 320 pixels with pixel value = x + 1 and pix_sof on the first, then run to line 524 swap -> VGA rows 0 and 1 show col 0,1 = 12'h001 and col 638,639 = 12'h140.
REQ-039 Starvation: stop pix_valid after line 5 -> one underflow pulse per odd row from row 11 onward, and rows repeat the line-5 data.
REQ-040 Backpressure: the fill buffer is full before the swap -> pix_ready=0 until the swap cycle, then 1 on the next clk with no pixel lost.
REQ-041 Mid-line pix_sof at wptr=100 -> the line restarts, and the next 320 pixels display correctly in row 0.
REQ-042 Blanking: video_on=0 with valid buffers -> rgb=12'h000; with the macro defined, 70000 underflows -> underflow_cnt=16'hFFFF.
